// File: rtl/syscall_unit.sv
// Clocked syscall execution unit: print-int (hex), print-string, print-char and exit,
// with a byte read port into data memory and a valid/ready console stream. Optional macro: SYSCALL_TRACE_EN.
module syscall_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MAX_STR_LEN = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              syscall_req,
    input  logic [DATA_W-1:0] v0,
    input  logic [DATA_W-1:0] a0,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready
);

    localparam int NIBBLES = DATA_W / 4;
    localparam int NIB_W   = $clog2(NIBBLES + 1);
    localparam int CNT_W   = $clog2(MAX_STR_LEN + 1);

    localparam logic [DATA_W-1:0] CODE_PRINT_INT  = DATA_W'(1);
    localparam logic [DATA_W-1:0] CODE_PRINT_STR  = DATA_W'(4);
    localparam logic [DATA_W-1:0] CODE_EXIT       = DATA_W'(10);
    localparam logic [DATA_W-1:0] CODE_PRINT_CHAR = DATA_W'(11);

    typedef enum logic [2:0] {
        IDLE,
        HEX_EMIT,
        CHAR_EMIT,
        STR_FETCH,
        STR_EMIT,
        HALTED
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] hex_shift;
    logic [NIB_W-1:0]  nib_cnt;
    logic [CNT_W-1:0]  byte_cnt;
    logic [ADDR_W-1:0] a0_addr;
    logic              bad_code;
    logic              truncate;
    logic              last_nibble;
    logic              last_byte;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // The string pointer is a byte address; a narrower argument is zero-extended.
    generate
        if (ADDR_W > DATA_W) begin : g_addr_ext
            assign a0_addr = {{(ADDR_W - DATA_W){1'b0}}, a0};
        end else begin : g_addr_trunc
            assign a0_addr = a0[ADDR_W-1:0];
        end
    endgenerate

    assign last_nibble = (nib_cnt == NIB_W'(1));
    assign last_byte   = (byte_cnt == CNT_W'(MAX_STR_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        out_valid  = 1'b0;
        mem_req    = 1'b0;
        bad_code   = 1'b0;
        truncate   = 1'b0;
        case (state)
            IDLE: begin
                busy = syscall_req;
                if (syscall_req) begin
                    case (v0)
                        CODE_PRINT_INT:  next_state = HEX_EMIT;
                        CODE_PRINT_STR:  next_state = STR_FETCH;
                        CODE_PRINT_CHAR: next_state = CHAR_EMIT;
                        CODE_EXIT:       next_state = HALTED;
                        default:         bad_code   = 1'b1;
                    endcase
                end
            end
            HEX_EMIT: begin
                out_valid = 1'b1;
                if (out_ready && last_nibble) begin
                    next_state = IDLE;
                end
            end
            CHAR_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            STR_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    next_state = (mem_rdata == 8'h00) ? IDLE : STR_EMIT;
                end
            end
            STR_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    truncate   = last_byte;
                    next_state = last_byte ? IDLE : STR_FETCH;
                end
            end
            HALTED: begin
                busy = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath registers follow the dispatch decision made by the next-state logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_shift <= '0;
            nib_cnt   <= '0;
            byte_cnt  <= '0;
            mem_addr  <= '0;
            out_data  <= '0;
            err       <= 1'b0;
            halted    <= 1'b0;
        end else begin
            err <= bad_code | truncate;
            case (state)
                IDLE: begin
                    case (next_state)
                        HEX_EMIT: begin
                            out_data  <= hex_ascii(a0[DATA_W-1 -: 4]);
                            hex_shift <= a0 << 4;
                            nib_cnt   <= NIB_W'(NIBBLES);
                        end
                        STR_FETCH: begin
                            mem_addr <= a0_addr;
                            byte_cnt <= '0;
                        end
                        CHAR_EMIT: begin
                            out_data <= a0[7:0];
                        end
                        HALTED: begin
                            halted <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                HEX_EMIT: begin
                    if (out_ready && !last_nibble) begin
                        out_data  <= hex_ascii(hex_shift[DATA_W-1 -: 4]);
                        hex_shift <= hex_shift << 4;
                        nib_cnt   <= nib_cnt - NIB_W'(1);
                    end
                end
                STR_FETCH: begin
                    if (mem_ack && (mem_rdata != 8'h00)) begin
                        out_data <= mem_rdata;
                    end
                end
                STR_EMIT: begin
                    if (out_ready) begin
                        byte_cnt <= byte_cnt + CNT_W'(1);
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SYSCALL_TRACE_EN
    string line_buf = "";
    logic  halted_q = 1'b0;

    // Console trace: buffer characters and flush on newline or when a syscall finishes.
    always @(posedge clk) begin
        if (rst_n) begin
            if (state == IDLE && syscall_req) begin
                $display("[syscall] code=%0d arg=0x%0h time=%0t", v0, a0, $time);
            end
            if (out_valid && out_ready) begin
                if (out_data == 8'h0a) begin
                    $display("%s", line_buf);
                    line_buf = "";
                end else begin
                    line_buf = $sformatf("%s%c", line_buf, out_data);
                end
            end
            if (state != IDLE && next_state == IDLE && line_buf != "") begin
                $display("%s", line_buf);
                line_buf = "";
            end
            if (halted && !halted_q) begin
                $display("Syscall received 10, kill execution.");
            end
            if (halted_q) begin
                $finish;
            end
            halted_q = halted;
        end else begin
            line_buf = "";
            halted_q = 1'b0;
        end
    end
`endif

endmodule
